// File: rtl/elevator_request_scheduler.sv
// Collective-SCAN request scheduler for a small elevator: latches cabin/hall
// requests, tracks floor and direction, and issues one-floor moves or door cycles.
module elevator_request_scheduler #(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = 2
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [N_FLOORS-1:0] cab_req_n,
    input  logic [N_FLOORS-1:0] hall_req,
    input  logic                mv_ready,
    input  logic                mv_done,
    input  logic                door_ready,
    input  logic                door_done,
    output logic                mv_valid,
    output logic                mv_up,
    output logic                door_valid,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic [1:0]          dir_state,
    output logic                busy,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECIDE, S_MOVE_REQ, S_MOVING, S_DOOR_REQ, S_DOOR
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    localparam int unsigned NF = N_FLOORS;

    state_t              state;
    dir_t                dir_q;
    logic [N_FLOORS-1:0] req_set;
    logic [N_FLOORS-1:0] req_clr;
    logic [N_FLOORS-1:0] pending_next;
    logic                has_up;
    logic                has_dn;
    logic                go_up;
    int unsigned         cur_u;
    int unsigned         dist_up;
    int unsigned         dist_dn;

    assign dir_state = dir_q;
    assign mv_up     = (dir_q == DIR_UP);

    // The car's own floor is masked during the door cycle so a held button
    // only re-registers once the door has finished.
    always_comb begin
        req_set = ~cab_req_n | hall_req;
        if (state == S_DOOR)
            req_set[cur_floor] = 1'b0;
        req_clr = '0;
        req_clr[cur_floor] = door_valid && door_ready;
        pending_next = (pending | req_set) & ~req_clr;
    end

    always_comb begin
        cur_u   = 32'(cur_floor);
        has_up  = 1'b0;
        has_dn  = 1'b0;
        dist_up = NF;
        dist_dn = NF;
        for (int unsigned i = 0; i < NF; i++) begin
            if (pending[i]) begin
                if (i > cur_u) begin
                    has_up = 1'b1;
                    if (i - cur_u < dist_up)
                        dist_up = i - cur_u;
                end else if (i < cur_u) begin
                    has_dn = 1'b1;
                    if (cur_u - i < dist_dn)
                        dist_dn = cur_u - i;
                end
            end
        end
        case (dir_q)
            DIR_UP:   go_up = has_up;
            DIR_DOWN: go_up = !has_dn;
            default:  go_up = has_up && (!has_dn || dist_up <= dist_dn);
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            dir_q      <= DIR_NONE;
            cur_floor  <= '0;
            pending    <= '0;
            mv_valid   <= 1'b0;
            door_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            pending <= pending_next;
            if ((mv_done && state != S_MOVING) || (door_done && state != S_DOOR))
                err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (pending != '0) begin
                        state <= S_DECIDE;
                        busy  <= 1'b1;
                    end
                end
                S_DECIDE: begin
                    if (pending == '0) begin
                        state <= S_IDLE;
                        dir_q <= DIR_NONE;
                        busy  <= 1'b0;
                    end else if (pending[cur_floor]) begin
                        state      <= S_DOOR_REQ;
                        door_valid <= 1'b1;
                    end else begin
                        state    <= S_MOVE_REQ;
                        mv_valid <= 1'b1;
                        dir_q    <= go_up ? DIR_UP : DIR_DOWN;
                    end
                end
                S_MOVE_REQ: begin
                    if (mv_ready) begin
                        state    <= S_MOVING;
                        mv_valid <= 1'b0;
                    end
                end
                S_MOVING: begin
                    if (mv_done) begin
                        cur_floor <= (dir_q == DIR_UP) ? cur_floor + FLOOR_W'(1)
                                                       : cur_floor - FLOOR_W'(1);
                        state     <= S_DECIDE;
                    end
                end
                S_DOOR_REQ: begin
                    if (door_ready) begin
                        state      <= S_DOOR;
                        door_valid <= 1'b0;
                    end
                end
                S_DOOR: begin
                    if (door_done)
                        state <= S_DECIDE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench: a SCAN reference model predicts each command; a monitor
// pops and compares at every accepted move/door handshake.
module tb_elevator_request_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cab_req_n, hall_req;
    logic       mv_ready, mv_done, door_ready, door_done;
    logic       mv_valid, mv_up, door_valid, busy, err;
    logic [1:0] cur_floor, dir_state;
    logic [3:0] pending;

    always #10 clk = ~clk;

    elevator_request_scheduler #(.N_FLOORS(4), .FLOOR_W(2)) dut (
        .CLOCK_50(clk), .RESET(rst), .cab_req_n(cab_req_n), .hall_req(hall_req),
        .mv_ready(mv_ready), .mv_done(mv_done), .door_ready(door_ready),
        .door_done(door_done), .mv_valid(mv_valid), .mv_up(mv_up),
        .door_valid(door_valid), .cur_floor(cur_floor), .pending(pending),
        .dir_state(dir_state), .busy(busy), .err(err)
    );

    typedef struct { bit is_move; bit up; int floor; } cmd_t;

    int   tests = 0;
    int   fails = 0;
    cmd_t exp_q[$];
    bit [3:0] m_pend;
    int   m_floor;
    int   m_dir;   // 0 none, 1 up, -1 down

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference SCAN policy: serve own floor, else keep heading while work
    // lies ahead, else reverse; from rest pick the nearest (ties go up).
    function automatic bit predict(output cmd_t c);
        bit above = 0, below = 0, found = 0, up = 0;
        c = '{0, 0, m_floor};
        if (m_pend == 4'b0000) begin
            m_dir = 0;
            return 0;
        end
        if (m_pend[m_floor]) return 1;
        for (int f = 0; f < 4; f++) begin
            if (m_pend[f] && f > m_floor) above = 1;
            if (m_pend[f] && f < m_floor) below = 1;
        end
        if (m_dir == 1) up = above;
        else if (m_dir == -1) up = !below;
        else begin
            for (int d = 1; d < 4; d++) begin
                if (!found && m_floor + d < 4 && m_pend[m_floor + d]) begin up = 1; found = 1; end
                if (!found && m_floor - d >= 0 && m_pend[m_floor - d]) begin up = 0; found = 1; end
            end
        end
        m_dir = up ? 1 : -1;
        c.is_move = 1;
        c.up = up;
        return 1;
    endfunction

    always @(negedge clk) begin
        cmd_t e;
        if (!rst && ((mv_valid && mv_ready) || (door_valid && door_ready))) begin
            check("exclusive_valid", int'(mv_valid && door_valid), 0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_cmd: got mv=%0d door=%0d expected none", mv_valid, door_valid);
            end else begin
                e = exp_q.pop_front();
                check("cmd_kind_is_move", int'(mv_valid), int'(e.is_move));
                if (e.is_move) check("mv_up", int'(mv_up), int'(e.up));
                check("cmd_floor", int'(cur_floor), e.floor);
            end
        end
    end

    task automatic wait_cmd(input int exp_edges);
        int n = 0;
        do begin
            tick;
            n++;
        end while (!(mv_valid || door_valid) && n < 20);
        if (!(mv_valid || door_valid)) begin
            fails++;
            $display("FAIL cmd_timeout: got no valid after %0d cycles expected %0d", n, exp_edges);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "no command from scheduler");
        end
        check("cmd_latency", n, exp_edges);
    endtask

    task automatic reset_mid_move;
        rst = 1'b1;
        #1;
        check("reset_outputs", int'({mv_valid, door_valid, busy, err, cur_floor, pending, dir_state}), 0);
        m_pend = '0; m_floor = 0; m_dir = 0;
        exp_q.delete();
        tick;
        rst = 1'b0;
        tick;
        check("busy_after_reset", int'(busy), 0);
        mv_done = 1'b1;
        tick;
        mv_done = 1'b0;
        check("err_stray_mv_done", int'(err), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        check("err_cleared", int'(err), 0);
    endtask

    task automatic run_trip(input logic [3:0] cab_mask, input logic [3:0] hall_mask,
                            input int inj_move, input logic [3:0] inj_mask, input int reset_move);
        cmd_t c;
        int   moves = 0;
        bit   first = 1;
        bit   more;
        cab_req_n = ~cab_mask;
        hall_req  = hall_mask;
        m_pend    = m_pend | cab_mask | hall_mask;
        tick;
        cab_req_n = '1;
        hall_req  = '0;
        check("pending_latch", int'(pending), int'(m_pend));
        more = predict(c);
        while (more) begin
            exp_q.push_back(c);
            wait_cmd(first ? 2 : 1);
            first = 0;
            if (c.is_move) check("dir_state_move", int'(dir_state), c.up ? 1 : 2);
            repeat ($urandom_range(0, 2)) tick;
            if (c.is_move) mv_ready = 1'b1; else door_ready = 1'b1;
            tick;
            mv_ready = 1'b0;
            door_ready = 1'b0;
            check("valid_drop", int'(mv_valid | door_valid), 0);
            if (c.is_move) begin
                if (moves == reset_move) begin
                    reset_mid_move();
                    return;
                end
                if (moves == inj_move) begin
                    tick;
                    hall_req = inj_mask;
                    m_pend = m_pend | inj_mask;
                    tick;
                    hall_req = '0;
                end
                moves++;
                repeat ($urandom_range(0, 2)) tick;
                mv_done = 1'b1;
                tick;
                mv_done = 1'b0;
                m_floor += c.up ? 1 : -1;
            end else begin
                m_pend[c.floor] = 1'b0;
                check("pending_after_door", int'(pending), int'(m_pend));
                repeat ($urandom_range(0, 3)) tick;
                door_done = 1'b1;
                tick;
                door_done = 1'b0;
            end
            more = predict(c);
        end
        tick;
        check("idle_busy", int'(busy), 0);
        check("idle_dir", int'(dir_state), 0);
        check("idle_pending", int'(pending), 0);
        check("idle_floor", int'(cur_floor), m_floor);
    endtask

    initial begin
        logic [3:0] rq, r1, r2;
        rst = 1'b1;
        cab_req_n = '1; hall_req = '0;
        mv_ready = 1'b0; mv_done = 1'b0; door_ready = 1'b0; door_done = 1'b0;
        m_pend = '0; m_floor = 0; m_dir = 0;
        #1;
        check("reset_state", int'({mv_valid, door_valid, busy, err, cur_floor, pending, dir_state}), 0);
        tick; tick;
        rst = 1'b0;
        tick;

        run_trip(4'b0100, 4'b0010, -1, 4'b0000, -1);  // floors 1 and 2 from 0
        run_trip(4'b0000, 4'b0001, -1, 4'b0000, -1);
        run_trip(4'b0000, 4'b1001, -1, 4'b0000, -1);  // door at 0 then up to 3
        run_trip(4'b0000, 4'b0010, -1, 4'b0000, -1);
        run_trip(4'b0010, 4'b0010, -1, 4'b0000, -1);  // double press at own floor
        run_trip(4'b0000, 4'b0001, -1, 4'b0000, -1);
        run_trip(4'b0000, 4'b1000, 0, 4'b0010, -1);   // pick-up at 1 on the way
        run_trip(4'b0000, 4'b0001, -1, 4'b0000, -1);
        run_trip(4'b0000, 4'b1000, 2, 4'b0001, -1);   // reversal after serving 3
        run_trip(4'b0000, 4'b1000, -1, 4'b0000, 1);   // reset mid-move

        for (int t = 0; t < 25; t++) begin
            rq = 4'($urandom_range(1, 15));
            r1 = 4'($urandom);
            r2 = 4'($urandom);
            run_trip((rq & ~r1) | (rq & r2), rq & r1,
                     int'($urandom_range(0, 4)) - 1, 4'($urandom), -1);
        end
        check("err_clean", int'(err), 0);

        door_done = 1'b1;
        tick;
        door_done = 1'b0;
        check("err_stray_door_done", int'(err), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
